// File: rtl/ajit_acc_pkg.sv
// Shared definitions for the AJIT accelerator DMA engine:
// ACB request/response field layout, engine states and copy constants.
package ajit_acc_pkg;

   localparam int ACB_REQ_W     = 110;
   localparam int ACB_RSP_W     = 65;
   localparam int ACB_DATA_W    = 64;

   localparam int REQ_LOCK_BIT  = 109;
   localparam int REQ_RWBAR_BIT = 108;
   localparam int REQ_BMASK_LSB = 100;
   localparam int REQ_BMASK_W   = 8;
   localparam int REQ_ADDR_LSB  = 64;
   localparam int REQ_ADDR_W    = 36;
   localparam int REQ_WDATA_LSB = 0;

   localparam int RSP_ERR_BIT   = 64;

   localparam logic [REQ_BMASK_W-1:0] BMASK_ALL = 8'hFF;
   localparam int DW_BYTES = 8;

   typedef enum logic [2:0] {
      IDLE,
      RD_REQ,
      RD_RSP,
      WR_REQ,
      WR_RSP,
      FINISH
   } dma_state_e;

endpackage

// File: rtl/ajit_acc_acb_req_fmt.sv
// Packs the individual ACB request fields into the 110-bit request word.
module ajit_acc_acb_req_fmt
   import ajit_acc_pkg::*;
#(
   parameter int ADDR_W = REQ_ADDR_W
) (
   input  logic                   lock,
   input  logic                   rwbar,
   input  logic [REQ_BMASK_W-1:0] bmask,
   input  logic [ADDR_W-1:0]      addr,
   input  logic [ACB_DATA_W-1:0]  wdata,
   output logic [ACB_REQ_W-1:0]   req_data
);

   always_comb begin
      req_data = '0;
      req_data[REQ_LOCK_BIT] = lock;
      req_data[REQ_RWBAR_BIT] = rwbar;
      req_data[REQ_BMASK_LSB +: REQ_BMASK_W] = bmask;
      req_data[REQ_ADDR_LSB +: ADDR_W] = addr;
      req_data[REQ_WDATA_LSB +: ACB_DATA_W] = wdata;
   end

endmodule

// File: rtl/ajit_acc_dma_engine.sv
// Doubleword memory-to-memory copy engine on the ACB: one read then one
// write per doubleword, at most one request outstanding.
module ajit_acc_dma_engine
   import ajit_acc_pkg::*;
#(
   parameter int LEN_W  = 16,
   parameter int ADDR_W = 36
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [ADDR_W-1:0]     src_addr,
   input  logic [ADDR_W-1:0]     dst_addr,
   input  logic [LEN_W-1:0]      len,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [ACB_REQ_W-1:0]  ACB_ACCELERATOR_MEM_REQUEST_pipe_read_data,
   output logic                  ACB_ACCELERATOR_MEM_REQUEST_pipe_read_ack,
   input  logic                  ACB_ACCELERATOR_MEM_REQUEST_pipe_read_req,
   input  logic [ACB_RSP_W-1:0]  ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_data,
   input  logic                  ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_req,
   output logic                  ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_ack
);

   dma_state_e state_q, state_d;
   logic [ADDR_W-1:0]     src_q, src_d;
   logic [ADDR_W-1:0]     dst_q, dst_d;
   logic [LEN_W-1:0]      rem_q, rem_d;
   logic [ACB_DATA_W-1:0] buf_q, buf_d;
   logic                  err_q, err_d;

   logic                   req_valid;
   logic                   req_ready;
   logic                   rsp_valid;
   logic                   rsp_ready;
   logic                   rsp_err;
   logic [ACB_DATA_W-1:0]  rsp_rdata;
   logic                   f_rwbar;
   logic [REQ_BMASK_W-1:0] f_bmask;
   logic [ADDR_W-1:0]      f_addr;
   logic [ACB_DATA_W-1:0]  f_wdata;

   assign req_ready = ACB_ACCELERATOR_MEM_REQUEST_pipe_read_req;
   assign rsp_valid = ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_req;
   assign rsp_err   = ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_data[RSP_ERR_BIT];
   assign rsp_rdata =
      ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_data[ACB_DATA_W-1:0];

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         rem_q   <= '0;
         buf_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         rem_q   <= rem_d;
         buf_q   <= buf_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      src_d     = src_q;
      dst_d     = dst_q;
      rem_d     = rem_q;
      buf_d     = buf_q;
      err_d     = err_q;
      req_valid = 1'b0;
      rsp_ready = 1'b0;
      f_rwbar   = 1'b0;
      f_bmask   = '0;
      f_addr    = '0;
      f_wdata   = '0;
      busy      = 1'b0;
      done      = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               src_d   = {src_addr[ADDR_W-1:3], 3'b000};
               dst_d   = {dst_addr[ADDR_W-1:3], 3'b000};
               rem_d   = len;
               err_d   = 1'b0;
               state_d = RD_REQ;
            end
         end
         RD_REQ: begin
            busy = 1'b1;
            // a zero-length copy spends one idle cycle here, never requesting
            if (rem_q == '0) begin
               state_d = FINISH;
            end else begin
               req_valid = 1'b1;
               f_rwbar   = 1'b1;
               f_bmask   = BMASK_ALL;
               f_addr    = src_q;
               if (req_ready) state_d = RD_RSP;
            end
         end
         RD_RSP: begin
            busy      = 1'b1;
            rsp_ready = 1'b1;
            if (rsp_valid) begin
               buf_d = rsp_rdata;
               if (rsp_err) begin
                  err_d   = 1'b1;
                  state_d = FINISH;
               end else begin
                  state_d = WR_REQ;
               end
            end
         end
         WR_REQ: begin
            busy      = 1'b1;
            req_valid = 1'b1;
            f_bmask   = BMASK_ALL;
            f_addr    = dst_q;
            f_wdata   = buf_q;
            if (req_ready) state_d = WR_RSP;
         end
         WR_RSP: begin
            busy      = 1'b1;
            rsp_ready = 1'b1;
            if (rsp_valid) begin
               if (rsp_err) begin
                  err_d   = 1'b1;
                  state_d = FINISH;
               end else begin
                  src_d   = src_q + ADDR_W'(DW_BYTES);
                  dst_d   = dst_q + ADDR_W'(DW_BYTES);
                  rem_d   = rem_q - LEN_W'(1);
                  state_d = (rem_q == LEN_W'(1)) ? FINISH : RD_REQ;
               end
            end
         end
         FINISH: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   ajit_acc_acb_req_fmt #(
      .ADDR_W(ADDR_W)
   ) u_req_fmt (
      .lock    (1'b0),
      .rwbar   (f_rwbar),
      .bmask   (f_bmask),
      .addr    (f_addr),
      .wdata   (f_wdata),
      .req_data(ACB_ACCELERATOR_MEM_REQUEST_pipe_read_data)
   );

   assign ACB_ACCELERATOR_MEM_REQUEST_pipe_read_ack   = req_valid;
   assign ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_ack = rsp_ready;
   assign error = err_q;

endmodule

// File: tb/tb_ajit_acc_dma_engine.sv
// Directed bench for ajit_acc_dma_engine with a small ACB memory responder
// whose read data is rd_base XOR address.
module tb_ajit_acc_dma_engine;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         start = 1'b0;
   logic [35:0]  src_addr = '0;
   logic [35:0]  dst_addr = '0;
   logic [15:0]  len = '0;
   logic         busy, done, error;
   logic [109:0] req_data;
   logic         req_valid;
   logic         req_ready = 1'b1;
   logic [64:0]  rsp_data = '0;
   logic         rsp_valid = 1'b1;
   logic         rsp_ready;

   ajit_acc_dma_engine #(.LEN_W(16), .ADDR_W(36)) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .src_addr(src_addr),
      .dst_addr(dst_addr),
      .len(len),
      .busy(busy),
      .done(done),
      .error(error),
      .ACB_ACCELERATOR_MEM_REQUEST_pipe_read_data(req_data),
      .ACB_ACCELERATOR_MEM_REQUEST_pipe_read_ack(req_valid),
      .ACB_ACCELERATOR_MEM_REQUEST_pipe_read_req(req_ready),
      .ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_data(rsp_data),
      .ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_req(rsp_valid),
      .ACB_ACCELERATOR_MEM_RESPONSE_pipe_write_ack(rsp_ready)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [109:0] log_q[$];
   logic [109:0] stall_q[$];
   int   done_count = 0;
   int   done_cyc = 0;
   int   valid_seen = 0;
   int   stall_used = 0;
   logic busy_at_done = 1'b0;

   int          stall_target = 0;
   logic [63:0] rd_base = '0;
   logic [35:0] err_addr = '1;

   int errors = 0;
   int checks = 0;
   int start_cyc = 0;

   // responder and monitor: everything observed on the falling edge
   always @(negedge clk) begin
      logic [35:0] a;
      if (req_valid && stall_used < stall_target) begin
         req_ready = 1'b0;
         stall_used++;
         stall_q.push_back(req_data);
      end else begin
         req_ready = 1'b1;
      end
      if (req_valid) valid_seen++;
      if (req_valid && req_ready) begin
         log_q.push_back(req_data);
         if (req_data[108]) begin
            a = req_data[99:64];
            rsp_data = {(a == err_addr), rd_base ^ {28'h0, a}};
         end
      end
      if (done) begin
         done_count++;
         done_cyc = cyc;
         busy_at_done = busy;
      end
   end

   function automatic logic [109:0] pkt(input logic rw,
                                        input logic [35:0] a,
                                        input logic [63:0] d);
      return {1'b0, rw, 8'hFF, a, d};
   endfunction

   function automatic logic [109:0] logged(input int idx);
      return (idx < log_q.size()) ? log_q[idx] : '0;
   endfunction

   task automatic do_start(input logic [35:0] s, input logic [35:0] d,
                           input logic [15:0] n);
      start = 1'b1;
      src_addr = s;
      dst_addr = d;
      len = n;
      start_cyc = cyc;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int d0);
      for (int i = 0; i < 200; i++) begin
         if (done_count != d0) break;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (busy !== 1'b0) begin errors++;
         $display("FAIL rst_busy got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++;
         $display("FAIL rst_done got %b want 0", done); end
      checks++; if (error !== 1'b0) begin errors++;
         $display("FAIL rst_error got %b want 0", error); end
      checks++; if (req_valid !== 1'b0) begin errors++;
         $display("FAIL rst_req_valid got %b want 0", req_valid); end
      checks++; if (req_data !== 110'h0) begin errors++;
         $display("FAIL rst_req_data got %h want 0", req_data); end
      checks++; if (rsp_ready !== 1'b0) begin errors++;
         $display("FAIL rst_rsp_ready got %b want 0", rsp_ready); end
      reset = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_single();
      int d0 = done_count;
      int b = log_q.size();
      rd_base = 64'hDEADBEEF_CAFEF00D ^ 64'h100;
      do_start(36'h100, 36'h200, 16'd1);
      checks++; if (busy !== 1'b1) begin errors++;
         $display("FAIL single_busy got %b want 1", busy); end
      wait_done(d0);
      checks++; if (done_count - d0 !== 1) begin errors++;
         $display("FAIL single_done_cnt got %0d want 1", done_count - d0); end
      checks++; if (done_cyc - start_cyc !== 5) begin errors++;
         $display("FAIL single_latency got %0d want 5", done_cyc - start_cyc); end
      checks++; if (busy_at_done !== 1'b0) begin errors++;
         $display("FAIL single_busy_at_done got %b want 0", busy_at_done); end
      checks++; if (log_q.size() - b !== 2) begin errors++;
         $display("FAIL single_xfers got %0d want 2", log_q.size() - b); end
      checks++; if (logged(b) !== pkt(1'b1, 36'h100, 64'h0)) begin errors++;
         $display("FAIL single_rd got %h want %h", logged(b),
                  pkt(1'b1, 36'h100, 64'h0)); end
      checks++;
      if (logged(b + 1) !== pkt(1'b0, 36'h200, 64'hDEADBEEF_CAFEF00D)) begin
         errors++;
         $display("FAIL single_wr got %h want %h", logged(b + 1),
                  pkt(1'b0, 36'h200, 64'hDEADBEEF_CAFEF00D)); end
      checks++; if (error !== 1'b0) begin errors++;
         $display("FAIL single_error got %b want 0", error); end
   endtask

   task automatic test_multi();
      int d0 = done_count;
      int b = log_q.size();
      logic [109:0] exp_q[6];
      rd_base = 64'h1111_2222_3333_0000;
      exp_q[0] = pkt(1'b1, 36'h1000, 64'h0);
      exp_q[1] = pkt(1'b0, 36'h2000, 64'h1111_2222_3333_1000);
      exp_q[2] = pkt(1'b1, 36'h1008, 64'h0);
      exp_q[3] = pkt(1'b0, 36'h2008, 64'h1111_2222_3333_1008);
      exp_q[4] = pkt(1'b1, 36'h1010, 64'h0);
      exp_q[5] = pkt(1'b0, 36'h2010, 64'h1111_2222_3333_1010);
      do_start(36'h1000, 36'h2000, 16'd3);
      @(posedge clk); #1;
      @(posedge clk); #1;
      start = 1'b1;
      src_addr = 36'h9000;
      dst_addr = 36'hA000;
      len = 16'd7;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(d0);
      checks++; if (done_count - d0 !== 1) begin errors++;
         $display("FAIL multi_done_cnt got %0d want 1", done_count - d0); end
      checks++; if (log_q.size() - b !== 6) begin errors++;
         $display("FAIL multi_xfers got %0d want 6", log_q.size() - b); end
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (logged(b + i) !== exp_q[i]) begin errors++;
            $display("FAIL multi_xfer%0d got %h want %h", i,
                     logged(b + i), exp_q[i]); end
      end
      repeat (3) @(posedge clk);
      #1;
      checks++; if (done_count - d0 !== 1) begin errors++;
         $display("FAIL multi_single_done got %0d want 1", done_count - d0); end
   endtask

   task automatic test_zero_len();
      int d0 = done_count;
      int v0 = valid_seen;
      int b = log_q.size();
      do_start(36'h3000, 36'h4000, 16'd0);
      wait_done(d0);
      checks++; if (done_count - d0 !== 1) begin errors++;
         $display("FAIL zero_done_cnt got %0d want 1", done_count - d0); end
      checks++; if (done_cyc - start_cyc !== 2) begin errors++;
         $display("FAIL zero_latency got %0d want 2", done_cyc - start_cyc); end
      checks++; if (valid_seen - v0 !== 0) begin errors++;
         $display("FAIL zero_valid got %0d want 0", valid_seen - v0); end
      checks++; if (log_q.size() - b !== 0) begin errors++;
         $display("FAIL zero_xfers got %0d want 0", log_q.size() - b); end
   endtask

   task automatic test_stall();
      int d0 = done_count;
      int b = log_q.size();
      int sb = stall_q.size();
      rd_base = '0;
      stall_target = stall_used + 5;
      do_start(36'h500, 36'h600, 16'd1);
      wait_done(d0);
      checks++; if (stall_q.size() - sb !== 5) begin errors++;
         $display("FAIL stall_cycles got %0d want 5", stall_q.size() - sb); end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (((sb + i) < stall_q.size() ? stall_q[sb + i] : '0) !==
             pkt(1'b1, 36'h500, 64'h0)) begin
            errors++;
            $display("FAIL stall_hold%0d got %h want %h", i,
                     (sb + i) < stall_q.size() ? stall_q[sb + i] : '0,
                     pkt(1'b1, 36'h500, 64'h0));
         end
      end
      checks++; if (log_q.size() - b !== 2) begin errors++;
         $display("FAIL stall_xfers got %0d want 2", log_q.size() - b); end
      checks++; if (logged(b + 1) !== pkt(1'b0, 36'h600, 64'h500)) begin
         errors++;
         $display("FAIL stall_wr got %h want %h", logged(b + 1),
                  pkt(1'b0, 36'h600, 64'h500)); end
      checks++; if (done_cyc - start_cyc !== 10) begin errors++;
         $display("FAIL stall_latency got %0d want 10", done_cyc - start_cyc); end
   endtask

   task automatic test_error();
      int d0 = done_count;
      int b = log_q.size();
      err_addr = 36'h808;
      rd_base = 64'hAAAA_0000_0000_0000;
      do_start(36'h800, 36'h900, 16'd4);
      wait_done(d0);
      err_addr = '1;
      checks++; if (done_count - d0 !== 1) begin errors++;
         $display("FAIL err_done_cnt got %0d want 1", done_count - d0); end
      checks++; if (log_q.size() - b !== 3) begin errors++;
         $display("FAIL err_xfers got %0d want 3", log_q.size() - b); end
      checks++;
      if (logged(b + 1) !== pkt(1'b0, 36'h900, 64'hAAAA_0000_0000_0800)) begin
         errors++;
         $display("FAIL err_wr0 got %h want %h", logged(b + 1),
                  pkt(1'b0, 36'h900, 64'hAAAA_0000_0000_0800)); end
      checks++; if (logged(b + 2) !== pkt(1'b1, 36'h808, 64'h0)) begin
         errors++;
         $display("FAIL err_rd1 got %h want %h", logged(b + 2),
                  pkt(1'b1, 36'h808, 64'h0)); end
      checks++; if (error !== 1'b1) begin errors++;
         $display("FAIL err_flag got %b want 1", error); end
      repeat (5) @(posedge clk);
      #1;
      checks++; if (error !== 1'b1) begin errors++;
         $display("FAIL err_sticky got %b want 1", error); end
      checks++; if (rsp_ready !== 1'b0) begin errors++;
         $display("FAIL err_idle_rsp_ready got %b want 0", rsp_ready); end
      checks++; if (log_q.size() - b !== 3) begin errors++;
         $display("FAIL err_no_more_req got %0d want 3", log_q.size() - b); end
   endtask

   task automatic test_back_to_back();
      int d0 = done_count;
      int b = log_q.size();
      rd_base = '0;
      do_start(36'h305, 36'h40F, 16'd1);
      checks++; if (error !== 1'b0) begin errors++;
         $display("FAIL b2b_err_clear got %b want 0", error); end
      wait_done(d0);
      do_start(36'h700, 36'h800, 16'd1);
      wait_done(d0 + 1);
      checks++; if (done_count - d0 !== 2) begin errors++;
         $display("FAIL b2b_done_cnt got %0d want 2", done_count - d0); end
      checks++; if (done_cyc - start_cyc !== 5) begin errors++;
         $display("FAIL b2b_latency got %0d want 5", done_cyc - start_cyc); end
      checks++; if (logged(b) !== pkt(1'b1, 36'h300, 64'h0)) begin errors++;
         $display("FAIL b2b_align_rd got %h want %h", logged(b),
                  pkt(1'b1, 36'h300, 64'h0)); end
      checks++; if (logged(b + 1) !== pkt(1'b0, 36'h408, 64'h300)) begin
         errors++;
         $display("FAIL b2b_align_wr got %h want %h", logged(b + 1),
                  pkt(1'b0, 36'h408, 64'h300)); end
      checks++; if (logged(b + 3) !== pkt(1'b0, 36'h800, 64'h700)) begin
         errors++;
         $display("FAIL b2b_second_wr got %h want %h", logged(b + 3),
                  pkt(1'b0, 36'h800, 64'h700)); end
   endtask

   task automatic test_wrap_reset();
      int d0 = done_count;
      int b = log_q.size();
      int wr = 0;
      rd_base = '0;
      do_start(36'hF_FFFF_FFF8, 36'h40, 16'd2);
      for (int i = 0; i < 100; i++) begin
         if (req_valid && !req_data[108]) begin
            wr++;
            if (wr == 2) break;
         end
         @(posedge clk); #1;
      end
      checks++; if (wr !== 2) begin errors++;
         $display("FAIL wrap_reach_wr got %0d want 2", wr); end
      checks++; if (logged(b) !== pkt(1'b1, 36'hF_FFFF_FFF8, 64'h0)) begin
         errors++;
         $display("FAIL wrap_rd0 got %h want %h", logged(b),
                  pkt(1'b1, 36'hF_FFFF_FFF8, 64'h0)); end
      checks++;
      if (logged(b + 1) !== pkt(1'b0, 36'h40, 64'hF_FFFF_FFF8)) begin
         errors++;
         $display("FAIL wrap_wr0 got %h want %h", logged(b + 1),
                  pkt(1'b0, 36'h40, 64'hF_FFFF_FFF8)); end
      checks++; if (logged(b + 2) !== pkt(1'b1, 36'h0, 64'h0)) begin
         errors++;
         $display("FAIL wrap_rd1 got %h want %h", logged(b + 2),
                  pkt(1'b1, 36'h0, 64'h0)); end
      reset = 1'b1;
      @(posedge clk); #1;
      checks++; if (busy !== 1'b0) begin errors++;
         $display("FAIL abort_busy got %b want 0", busy); end
      checks++; if (req_valid !== 1'b0) begin errors++;
         $display("FAIL abort_req_valid got %b want 0", req_valid); end
      checks++; if (req_data !== 110'h0) begin errors++;
         $display("FAIL abort_req_data got %h want 0", req_data); end
      checks++; if (rsp_ready !== 1'b0) begin errors++;
         $display("FAIL abort_rsp_ready got %b want 0", rsp_ready); end
      checks++; if (done !== 1'b0 || error !== 1'b0) begin errors++;
         $display("FAIL abort_done_err got %b%b want 00", done, error); end
      reset = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      checks++; if (done_count - d0 !== 0) begin errors++;
         $display("FAIL abort_no_done got %0d want 0", done_count - d0); end
      checks++; if (busy !== 1'b0) begin errors++;
         $display("FAIL abort_idle_busy got %b want 0", busy); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_multi();
      test_zero_len();
      test_stall();
      test_error();
      test_back_to_back();
      test_wrap_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
